// File: rtl/grid_game_pkg.sv
// Shared types and constants for the grid game controller: FSM states,
// winner encodings and active-low 7-segment glyphs.
package grid_game_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [6:0] SEG_ONE  = 7'b1111001;
  localparam logic [6:0] SEG_TWO  = 7'b0100100;
  localparam logic [6:0] SEG_P    = 7'b0001100;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Digit shown for a player: 1'b0 is player 1, 1'b1 is player 2.
  function automatic logic [6:0] player_seg(input logic player);
    return player ? SEG_TWO : SEG_ONE;
  endfunction

endpackage

// File: rtl/grid_game_ctrl_button_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-flop synchroniser, optional
// debounce (build with DEBOUNCE_EN), registered rising-edge detect.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic level_s;

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_r;
  logic          level_r;

  // Accept a new level only after it has held for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
    end else if (sync2_r != level_r) begin
      if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  assign level_s = level_r;
`else
  assign level_s = sync2_r;
`endif

  // Synchronise the raw input and register the rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      prev_r  <= level_s;
      pulse   <= level_s & ~prev_r;
    end
  end

endmodule

// File: rtl/grid_game_ctrl.sv
// N x N turn-based grid game: cursor, board ownership, turn and win/draw
// tracking with 7-seg status. Define DEBOUNCE_EN to debounce the buttons.
module grid_game_ctrl
  import grid_game_pkg::*;
#(
  parameter int GRID_N          = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enter,
  input  logic                     up_button,
  input  logic                     side_button,
  output logic [GRID_N*GRID_N-1:0] cursor_leds,
  output logic [GRID_N*GRID_N-1:0] p1_cells,
  output logic [GRID_N*GRID_N-1:0] p2_cells,
  output logic [1:0]               winner,
  output logic                     game_over,
  output logic [6:0]               hex1,
  output logic [6:0]               hex0
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam int IW    = $clog2(GRID_N);

  state_t          state_r;
  logic            player_r;
  logic [IW-1:0]   row_r;
  logic [IW-1:0]   col_r;
  logic [IW-1:0]   row_nxt_s;
  logic [IW-1:0]   col_nxt_s;
  logic [CELLS-1:0] cursor_nxt_s;
  logic [CELLS-1:0] cur_board_s;
  logic            enter_p_s;
  logic            up_p_s;
  logic            side_p_s;
  logic            win_s;
  logic            full_s;
  logic            occupied_s;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset(reset), .raw(enter), .pulse(enter_p_s));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .raw(up_button), .pulse(up_p_s));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_side (
    .clk(clk), .reset(reset), .raw(side_button), .pulse(side_p_s));

  // True when the board holds a complete row, column or either diagonal.
  function automatic logic has_line(input logic [CELLS-1:0] b);
    logic found;
    logic row_ok;
    logic col_ok;
    logic diag_ok;
    logic anti_ok;
    found   = 1'b0;
    diag_ok = 1'b1;
    anti_ok = 1'b1;
    for (int r = 0; r < GRID_N; r++) begin
      row_ok = 1'b1;
      col_ok = 1'b1;
      for (int c = 0; c < GRID_N; c++) begin
        row_ok = row_ok & b[r*GRID_N + c];
        col_ok = col_ok & b[c*GRID_N + r];
      end
      found   = found | row_ok | col_ok;
      diag_ok = diag_ok & b[r*GRID_N + r];
      anti_ok = anti_ok & b[r*GRID_N + (GRID_N - 1 - r)];
    end
    return found | diag_ok | anti_ok;
  endfunction

  // Wrapping cursor step and its one-hot image.
  always_comb begin
    row_nxt_s = row_r;
    col_nxt_s = col_r;
    if (up_p_s) begin
      row_nxt_s = (row_r == IW'(GRID_N - 1)) ? {IW{1'b0}} : row_r + IW'(1);
    end else begin
      row_nxt_s = row_r;
    end
    if (side_p_s) begin
      col_nxt_s = (col_r == IW'(GRID_N - 1)) ? {IW{1'b0}} : col_r + IW'(1);
    end else begin
      col_nxt_s = col_r;
    end
    cursor_nxt_s = CELLS'(1'b1) << (int'(row_nxt_s) * GRID_N + int'(col_nxt_s));
  end

  assign cur_board_s = player_r ? p2_cells : p1_cells;
  assign win_s       = has_line(cur_board_s);
  assign full_s      = &(p1_cells | p2_cells);
  assign occupied_s  = |(cursor_leds & (p1_cells | p2_cells));

  // Game FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= PLAY;
      player_r    <= 1'b0;
      row_r       <= {IW{1'b0}};
      col_r       <= {IW{1'b0}};
      cursor_leds <= CELLS'(1'b1);
      p1_cells    <= {CELLS{1'b0}};
      p2_cells    <= {CELLS{1'b0}};
      winner      <= WIN_NONE;
      game_over   <= 1'b0;
      hex1        <= SEG_P;
      hex0        <= SEG_ONE;
    end else begin
      case (state_r)
        PLAY: begin
          if (enter_p_s) begin
            if (!occupied_s) begin
              if (player_r) p2_cells <= p2_cells | cursor_leds;
              else          p1_cells <= p1_cells | cursor_leds;
              state_r <= CHECK;
            end
          end else begin
            row_r       <= row_nxt_s;
            col_r       <= col_nxt_s;
            cursor_leds <= cursor_nxt_s;
          end
        end
        CHECK: begin
          if (win_s) begin
            state_r   <= OVER;
            winner    <= player_r ? WIN_P2 : WIN_P1;
            game_over <= 1'b1;
            hex1      <= SEG_P;
            hex0      <= player_seg(player_r);
          end else if (full_s) begin
            state_r   <= OVER;
            winner    <= WIN_DRAW;
            game_over <= 1'b1;
            hex1      <= SEG_DASH;
            hex0      <= SEG_DASH;
          end else begin
            state_r  <= PLAY;
            player_r <= ~player_r;
            hex0     <= player_seg(~player_r);
          end
        end
        OVER: begin
          if (enter_p_s) begin
            state_r     <= PLAY;
            player_r    <= 1'b0;
            row_r       <= {IW{1'b0}};
            col_r       <= {IW{1'b0}};
            cursor_leds <= CELLS'(1'b1);
            p1_cells    <= {CELLS{1'b0}};
            p2_cells    <= {CELLS{1'b0}};
            winner      <= WIN_NONE;
            game_over   <= 1'b0;
            hex1        <= SEG_P;
            hex0        <= SEG_ONE;
          end
        end
        default: state_r <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_game_ctrl.sv
// Self-checking bench for grid_game_ctrl: directed scenarios plus random play
// against an array-based game model; a second instance runs a 4x4 board.
module tb_grid_game_ctrl;

`ifdef DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int LAT    = 3 + DB;
  localparam int HOLD   = DB + 2;
  localparam int SETTLE = DB + 6;

  localparam logic [6:0] G_ONE  = 7'b1111001;
  localparam logic [6:0] G_TWO  = 7'b0100100;
  localparam logic [6:0] G_P    = 7'b0001100;
  localparam logic [6:0] G_DASH = 7'b0111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en3 = 1'b0, up3 = 1'b0, sd3 = 1'b0;
  logic en4 = 1'b0, up4 = 1'b0, sd4 = 1'b0;

  logic [8:0]  cursor3, p1_3, p2_3;
  logic [15:0] cursor4, p1_4, p2_4;
  logic [1:0]  winner3, winner4;
  logic        over3, over4;
  logic [6:0]  hex1_3, hex0_3, hex1_4, hex0_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  grid_game_ctrl #(.GRID_N(3), .DEBOUNCE_CYCLES(16)) dut3 (
    .clk(clk), .reset(reset), .enter(en3), .up_button(up3), .side_button(sd3),
    .cursor_leds(cursor3), .p1_cells(p1_3), .p2_cells(p2_3), .winner(winner3),
    .game_over(over3), .hex1(hex1_3), .hex0(hex0_3));

  grid_game_ctrl #(.GRID_N(4), .DEBOUNCE_CYCLES(16)) dut4 (
    .clk(clk), .reset(reset), .enter(en4), .up_button(up4), .side_button(sd4),
    .cursor_leds(cursor4), .p1_cells(p1_4), .p2_cells(p2_4), .winner(winner4),
    .game_over(over4), .hex1(hex1_4), .hex0(hex0_4));

  // ---------------- behavioural game model ----------------
  int m_n, m_row, m_col, m_player, m_winner;
  bit m_over;
  int m_cell [64];

  task automatic model_reset(input int n);
    m_n = n; m_row = 0; m_col = 0; m_player = 1; m_winner = 0; m_over = 0;
    for (int i = 0; i < 64; i++) m_cell[i] = 0;
  endtask

  function automatic bit model_line(input int p);
    bit d = 1, a = 1, any = 0;
    for (int r = 0; r < m_n; r++) begin
      bit rw = 1, cl = 1;
      for (int c = 0; c < m_n; c++) begin
        if (m_cell[r*m_n + c] != p) rw = 0;
        if (m_cell[c*m_n + r] != p) cl = 0;
      end
      if (rw || cl) any = 1;
      if (m_cell[r*m_n + r] != p) d = 0;
      if (m_cell[r*m_n + (m_n - 1 - r)] != p) a = 0;
    end
    return any || d || a;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < m_n*m_n; i++) if (m_cell[i] == 0) return 0;
    return 1;
  endfunction

  task automatic model_press(input bit e, input bit u, input bit s);
    int idx;
    if (m_over) begin
      if (e) model_reset(m_n);
    end else if (e) begin
      idx = m_row*m_n + m_col;
      if (m_cell[idx] == 0) begin
        m_cell[idx] = m_player;
        if (model_line(m_player)) begin m_over = 1; m_winner = m_player; end
        else if (model_full()) begin m_over = 1; m_winner = 3; end
        else m_player = 3 - m_player;
      end
    end else begin
      if (u) m_row = (m_row + 1) % m_n;
      if (s) m_col = (m_col + 1) % m_n;
    end
  endtask

  function automatic logic [63:0] exp_cells(input int p);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < m_n*m_n; i++) if (m_cell[i] == p) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_cursor();
    return 64'd1 << (m_row*m_n + m_col);
  endfunction

  function automatic logic [16:0] exp_status();
    logic [6:0] h1, h0;
    if (m_over && m_winner == 3) begin h1 = G_DASH; h0 = G_DASH; end
    else if (m_over) begin h1 = G_P; h0 = (m_winner == 1) ? G_ONE : G_TWO; end
    else begin h1 = G_P; h0 = (m_player == 1) ? G_ONE : G_TWO; end
    return {2'(m_winner), m_over, h1, h0};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    {en3, up3, sd3, en4, up4, sd4} = 6'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_reset(n);
  endtask

  task automatic press(input int sel, input bit e, input bit u, input bit s);
    @(negedge clk);
    if (sel == 4) {en4, up4, sd4} = {e, u, s};
    else          {en3, up3, sd3} = {e, u, s};
    repeat (HOLD) @(negedge clk);
    {en3, up3, sd3, en4, up4, sd4} = 6'b0;
    repeat (SETTLE) @(negedge clk);
    model_press(e, u, s);
  endtask

  task automatic goto_cell(input int sel, input int r, input int c);
    for (int k = 0; k < 8 && m_row != r; k++) press(sel, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8 && m_col != c; k++) press(sel, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic claim(input int sel, input int r, input int c);
    goto_cell(sel, r, c);
    press(sel, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(3);
    n_checks++; if (cursor3 !== 9'h001) begin n_fail++; $display("FAIL reset_cursor got %h want 001", cursor3); end
    n_checks++; if ((p1_3 | p2_3) !== 9'h000) begin n_fail++; $display("FAIL reset_boards got %h/%h want 0", p1_3, p2_3); end
    n_checks++; if ({winner3, over3} !== 3'b000) begin n_fail++; $display("FAIL reset_result got %b%b want 000", winner3, over3); end
    n_checks++; if ({hex1_3, hex0_3} !== {G_P, G_ONE}) begin n_fail++; $display("FAIL reset_hex got %b %b want %b %b", hex1_3, hex0_3, G_P, G_ONE); end
  endtask

  task automatic test_latency();
    do_reset(3);
    @(negedge clk); up3 = 1'b1;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    #1;
    n_checks++; if (cursor3 !== 9'h001) begin n_fail++; $display("FAIL latency_early got %h want 001", cursor3); end
    @(posedge clk); #1;
    n_checks++; if (cursor3 !== 9'h008) begin n_fail++; $display("FAIL latency_edge got %h want 008", cursor3); end
    @(negedge clk); up3 = 1'b0;
    repeat (SETTLE) @(negedge clk);
    model_press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_cursor();
    logic [8:0] want [3];
    want[0] = 9'h008; want[1] = 9'h040; want[2] = 9'h001;
    do_reset(3);
    for (int i = 0; i < 3; i++) begin
      press(3, 1'b0, 1'b1, 1'b0);
      n_checks++; if (cursor3 !== want[i]) begin n_fail++; $display("FAIL cursor_up%0d got %h want %h", i, cursor3, want[i]); end
    end
    press(3, 1'b0, 1'b0, 1'b1);
    n_checks++; if (cursor3 !== 9'h002) begin n_fail++; $display("FAIL cursor_side got %h want 002", cursor3); end
    do_reset(3);
    press(3, 1'b0, 1'b1, 1'b1);
    n_checks++; if (cursor3 !== 9'h010) begin n_fail++; $display("FAIL cursor_both got %h want 010", cursor3); end
    press(3, 1'b1, 1'b1, 1'b0);
    n_checks++; if ({cursor3, p1_3} !== {9'h010, 9'h010}) begin n_fail++; $display("FAIL enter_priority got %h %h want 010 010", cursor3, p1_3); end
  endtask

  task automatic test_occupied();
    do_reset(3);
    claim(3, 0, 0);
    press(3, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({p1_3, p2_3} !== {9'h001, 9'h000}) begin n_fail++; $display("FAIL occupied_boards got %h %h want 001 000", p1_3, p2_3); end
    n_checks++; if (hex0_3 !== G_TWO) begin n_fail++; $display("FAIL occupied_hex0 got %b want %b", hex0_3, G_TWO); end
  endtask

  task automatic test_row_win();
    do_reset(3);
    claim(3, 0, 0); claim(3, 1, 0); claim(3, 0, 1); claim(3, 1, 1); claim(3, 0, 2);
    n_checks++; if (p1_3 !== 9'h007) begin n_fail++; $display("FAIL win_p1 got %h want 007", p1_3); end
    n_checks++; if ({winner3, over3} !== 3'b011) begin n_fail++; $display("FAIL win_result got %b%b want 011", winner3, over3); end
    n_checks++; if ({hex1_3, hex0_3} !== {G_P, G_ONE}) begin n_fail++; $display("FAIL win_hex got %b %b", hex1_3, hex0_3); end
    press(3, 1'b0, 1'b1, 1'b1);
    n_checks++; if (cursor3 !== 9'h004) begin n_fail++; $display("FAIL over_cursor got %h want 004", cursor3); end
  endtask

  task automatic test_draw();
    int order [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    do_reset(3);
    foreach (order[i]) claim(3, order[i] / 3, order[i] % 3);
    n_checks++; if ({winner3, over3} !== 3'b111) begin n_fail++; $display("FAIL draw_result got %b%b want 111", winner3, over3); end
    n_checks++; if ({hex1_3, hex0_3} !== {G_DASH, G_DASH}) begin n_fail++; $display("FAIL draw_hex got %b %b want dashes", hex1_3, hex0_3); end
    press(3, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({cursor3, p1_3, p2_3} !== {9'h001, 9'h000, 9'h000}) begin n_fail++; $display("FAIL restart_board got %h %h %h", cursor3, p1_3, p2_3); end
    n_checks++; if ({winner3, over3, hex0_3} !== {3'b000, G_ONE}) begin n_fail++; $display("FAIL restart_status got %b%b %b", winner3, over3, hex0_3); end
  endtask

  task automatic test_midgame_reset();
    do_reset(3);
    claim(3, 1, 1);
    press(3, 1'b0, 1'b0, 1'b1);
    do_reset(3);
    n_checks++; if ({cursor3, p1_3, p2_3} !== {9'h001, 9'h000, 9'h000}) begin n_fail++; $display("FAIL midreset_board got %h %h %h", cursor3, p1_3, p2_3); end
    n_checks++; if ({hex1_3, hex0_3} !== {G_P, G_ONE}) begin n_fail++; $display("FAIL midreset_hex got %b %b", hex1_3, hex0_3); end
    press(3, 1'b0, 1'b0, 1'b1);
    n_checks++; if (cursor3 !== 9'h002) begin n_fail++; $display("FAIL midreset_move got %h want 002", cursor3); end
  endtask

  task automatic test_grid4();
    int p1r [4] = '{0, 1, 2, 3};
    do_reset(4);
    for (int i = 0; i < 4; i++) begin
      claim(4, p1r[i], 3 - p1r[i]);
      if (i < 3) claim(4, 0, i);
    end
    n_checks++; if ({p1_4, p2_4} !== {16'h1248, 16'h0007}) begin n_fail++; $display("FAIL g4_boards got %h %h want 1248 0007", p1_4, p2_4); end
    n_checks++; if ({winner4, over4} !== 3'b011) begin n_fail++; $display("FAIL g4_result got %b%b want 011", winner4, over4); end
  endtask

  task automatic test_glitch();
`ifdef DEBOUNCE_EN
    do_reset(3);
    @(negedge clk); up3 = 1'b1;
    repeat (5) @(negedge clk);
    up3 = 1'b0;
    repeat (SETTLE) @(negedge clk);
    n_checks++; if (cursor3 !== 9'h001) begin n_fail++; $display("FAIL glitch got %h want 001", cursor3); end
`endif
  endtask

  task automatic test_random();
    do_reset(3);
    for (int step = 0; step < 200; step++) begin
      int r;
      bit e, u, s;
      r = $urandom_range(0, 9);
      e = (r >= 7);
      u = (r <= 2) || (r == 6) || (r == 9);
      s = (r >= 3 && r <= 6);
      press(3, e, u, s);
      n_checks++; if ({55'd0, cursor3} !== exp_cursor()) begin n_fail++; $display("FAIL rnd%0d_cursor got %h want %h", step, cursor3, exp_cursor()); end
      n_checks++; if ({55'd0, p1_3} !== exp_cells(1)) begin n_fail++; $display("FAIL rnd%0d_p1 got %h want %h", step, p1_3, exp_cells(1)); end
      n_checks++; if ({55'd0, p2_3} !== exp_cells(2)) begin n_fail++; $display("FAIL rnd%0d_p2 got %h want %h", step, p2_3, exp_cells(2)); end
      n_checks++; if ({winner3, over3, hex1_3, hex0_3} !== exp_status()) begin n_fail++; $display("FAIL rnd%0d_status got %b want %b", step, {winner3, over3, hex1_3, hex0_3}, exp_status()); end
    end
  endtask

  initial begin
    model_reset(3);
    test_reset();
    test_latency();
    test_cursor();
    test_occupied();
    test_row_win();
    test_draw();
    test_midgame_reset();
    test_grid4();
    test_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
